// File: rtl/stopwatch_up_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the count-up stopwatch:
//   - sw_state_e : controller state encoding (IDLE=0, RUN=1, PAUSED=2, SAT=3)
//   - BCD_MAX    : largest legal BCD digit value
//   - seg7_encode: active-low DE2 seven-segment table (used only when the
//                  STOPWATCH_HEX_EN build option is enabled)
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_SAT    = 2'd3
    } sw_state_e;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    // Non-BCD codes blank the display instead of showing garbage.
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0011000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/stopwatch_up_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decimal counter stage of the stopwatch. Stages are chained through
// carry: the carry of one stage is the inc of the next.
// Ports:
//   CLOCK_50 : clock (posedge)
//   reset    : synchronous active-high reset, clears the digit
//   clr      : synchronous clear, clears the digit
//   inc      : advance the digit by one this cycle
//   sat_hold : suppress the increment (whole counter sits at its maximum)
//   q        : registered BCD digit, never above 9
//   carry    : combinational, high when inc arrives while the digit is at 9
// -----------------------------------------------------------------------------
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic       sat_hold,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Next digit value: clear, hold, or increment with 9 -> 0 rollover.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (inc && !sat_hold) begin
            // >= also folds any illegal code back to 0
            if (q_q >= BCD_MAX) begin
                q_d = 4'd0;
            end else begin
                q_d = q_q + 4'd1;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Digit register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q >= BCD_MAX);

endmodule

// File: rtl/stopwatch_up.sv
// -----------------------------------------------------------------------------
// stopwatch_up
// Count-up response-time stopwatch, 00.0 .. 99.9 s in BCD. A push-button
// (active-low, asynchronous) toggles RUN/PAUSED; reaching 99.9 saturates.
// Build option: STOPWATCH_HEX_EN adds active-low seven-segment outputs.
// Parameters:
//   DIV         : CLOCK_50 cycles per 0.1 s tick (>= 2)
//   SYNC_STAGES : button synchroniser depth (>= 2)
// Ports:
//   CLOCK_50   : clock (posedge)
//   reset      : synchronous active-high reset
//   key_n      : raw start/stop button, active-low, asynchronous
//   clr        : synchronous clear back to IDLE / 00.0
//   tenths     : BCD tenths digit
//   sec_ones   : BCD seconds-ones digit
//   sec_tens   : BCD seconds-tens digit
//   running    : high while in RUN
//   ovf        : high while in SAT
//   stop_pulse : one-cycle pulse after a RUN -> PAUSED transition
//   hex0..hex2 : (STOPWATCH_HEX_EN only) segments for tenths/ones/tens
// -----------------------------------------------------------------------------
module stopwatch_up
    import stopwatch_pkg::*;
#(
    parameter int DIV         = 5000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_n,
    input  logic       clr,
    output logic [3:0] tenths,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic       running,
    output logic       ovf,
    output logic       stop_pulse
`ifdef STOPWATCH_HEX_EN
    ,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2
`endif
);

    localparam int             PW         = $clog2(DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]  PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);

    // Button path
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ks_prev_q;
    logic                   ks_s;
    logic                   press_s;

    // Controller
    sw_state_e       state_q;
    sw_state_e       state_d;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic            tick_s;
    logic            running_q;
    logic            ovf_q;
    logic            stop_pulse_q;

    // Digit chain
    logic [3:0]      tenths_s;
    logic [3:0]      ones_s;
    logic [3:0]      tens_s;
    logic            tenths_carry_s;
    logic            ones_carry_s;
    logic            sat_evt_s;
    logic            all_nine_s;
    logic            digit_clr_s;

    // Button synchroniser and previous-sample flop; released level is 1.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q    <= {SYNC_STAGES{1'b1}};
            ks_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], key_n};
            ks_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ks_s    = sync_q[SYNC_STAGES-1];
    assign press_s = ks_prev_q & ~ks_s;

    assign tick_s     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign all_nine_s = (tenths_s == BCD_MAX) && (ones_s == BCD_MAX) &&
                        (tens_s == BCD_MAX);

    // Next state and prescaler. clr overrides any press or tick. A tick at
    // 99.9 wins over a simultaneous press so the counter cannot pause at a
    // value it is about to saturate on.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        if (clr) begin
            state_d = ST_IDLE;
            presc_d = PRESC_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = PRESC_ZERO;
                    if (press_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        presc_d = PRESC_ZERO;
                    end else begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                    if (sat_evt_s) begin
                        state_d = ST_SAT;
                    end else if (press_s) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSED: begin
                    if (press_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_SAT: begin
                    state_d = ST_SAT;
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = PRESC_ZERO;
                end
            endcase
        end
    end

    // State, prescaler and status flags. Flags are computed from the next
    // state so they change on the same edge as the state itself.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= PRESC_ZERO;
            running_q    <= 1'b0;
            ovf_q        <= 1'b0;
            stop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            running_q    <= (state_d == ST_RUN);
            ovf_q        <= (state_d == ST_SAT);
            stop_pulse_q <= (state_q == ST_RUN) && (state_d == ST_PAUSED);
        end
    end

    // Digits are held at zero throughout IDLE, so entering RUN starts at 00.0.
    assign digit_clr_s = clr | (state_q == ST_IDLE);

    bcd_digit u_tenths (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clr      (digit_clr_s),
        .inc      (tick_s),
        .sat_hold (all_nine_s),
        .q        (tenths_s),
        .carry    (tenths_carry_s)
    );

    bcd_digit u_ones (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clr      (digit_clr_s),
        .inc      (tenths_carry_s),
        .sat_hold (all_nine_s),
        .q        (ones_s),
        .carry    (ones_carry_s)
    );

    // The carry out of the tens digit is exactly "tick while at 99.9",
    // i.e. the saturation event.
    bcd_digit u_tens (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clr      (digit_clr_s),
        .inc      (ones_carry_s),
        .sat_hold (all_nine_s),
        .q        (tens_s),
        .carry    (sat_evt_s)
    );

    assign tenths     = tenths_s;
    assign sec_ones   = ones_s;
    assign sec_tens   = tens_s;
    assign running    = running_q;
    assign ovf        = ovf_q;
    assign stop_pulse = stop_pulse_q;

`ifdef STOPWATCH_HEX_EN
    assign hex0 = seg7_encode(tenths_s);
    assign hex1 = seg7_encode(ones_s);
    assign hex2 = seg7_encode(tens_s);
`endif

endmodule
